// File: rtl/vend_pkg.sv
// Shared types for the multi-channel spiral vending controller: FSM encoding,
// key-code constants and the keypad matrix decode.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GET_CNT,
        ST_RUN,
        ST_FAULT
    } state_t;

    localparam logic [3:0] NO_KEY = 4'h0;
    localparam logic [3:0] CANCEL = 4'hA;

    // Exactly one column and one row bit must be set; anything else is no key.
    function automatic logic [3:0] key_decode(input logic [2:0] col, input logic [3:0] row);
        logic [1:0] c;
        logic [2:0] r;
        logic [3:0] res;
        res = NO_KEY;
        case (col)
            3'b100:  c = 2'd1;
            3'b010:  c = 2'd2;
            3'b001:  c = 2'd3;
            default: c = 2'd0;
        endcase
        case (row)
            4'b1000: r = 3'd1;
            4'b0100: r = 3'd2;
            4'b0010: r = 3'd3;
            4'b0001: r = 3'd4;
            default: r = 3'd0;
        endcase
        if (c != 2'd0 && r != 3'd0) begin
            if (r == 3'd4)
                res = (c == 2'd1) ? CANCEL : NO_KEY;
            else
                res = 4'(r - 3'd1) * 4'd3 + 4'(c);
        end
        return res;
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd9);
    endfunction

endpackage

// File: rtl/vend_key_deb.sv
// Keypad decode and debounce: one key_evt pulse per accepted press, re-armed
// only after the keypad has been quiet for KEY_DEB cycles.
module vend_key_deb
    import vend_pkg::*;
#(
    parameter int KEY_DEB = 16
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic [2:0] coluna_in,
    input  logic [3:0] linha_in,
    output logic       key_evt,
    output logic [3:0] key_code
);

    localparam int CW = $clog2(KEY_DEB + 1);

    logic [3:0]    code_now;
    logic [3:0]    code_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nx;
    logic          ready_q;
    logic          stable;

    assign code_now = key_decode(coluna_in, linha_in);

    // cnt counts consecutive samples equal to code_q, saturating at KEY_DEB
    always_comb begin
        cnt_nx = cnt_q;
        if (code_now != code_q)
            cnt_nx = CW'(1);
        else if (cnt_q != CW'(KEY_DEB))
            cnt_nx = cnt_q + CW'(1);
    end

    assign stable = (cnt_nx == CW'(KEY_DEB));

    // ready_q starts low so a key held through reset cannot fire
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            code_q   <= NO_KEY;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            key_evt  <= 1'b0;
            key_code <= NO_KEY;
        end else begin
            code_q  <= code_now;
            cnt_q   <= cnt_nx;
            key_evt <= 1'b0;
            if (stable && code_now == NO_KEY) begin
                ready_q <= 1'b1;
            end else if (stable && ready_q) begin
                key_evt  <= 1'b1;
                key_code <= code_now;
                ready_q  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-channel spiral vending controller: keypad selects channel and turn
// count, the selected channel's sensor pair counts turns, with a per-turn timeout.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 4,
    parameter int KEY_DEB = 16,
    parameter int SNS_DEB = 16,
    parameter int TURN_TO = 4096
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic [2:0]       coluna_in,
    input  logic [3:0]       linha_in,
    input  logic [N_CH-1:0]  sensor1_in,
    input  logic [N_CH-1:0]  sensor2_in,
    output logic [N_CH-1:0]  rele_out,
    output logic             busy_out,
    output logic             fault_out,
    output logic [3:0]       ch_out,
    output logic [CNT_W-1:0] remaining_out
);

    localparam int SW = $clog2(SNS_DEB + 1);
    localparam int TW = $clog2(TURN_TO + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_nx;
    logic [3:0]       ch_q, ch_nx;
    logic [CNT_W-1:0] rem_q, rem_nx;
    logic             armed_q, armed_nx;
    logic [SW-1:0]    scnt_q, scnt_nx;
    logic [TW-1:0]    tcnt_q, tcnt_nx;
    logic             busy_q, fault_q;

    logic             key_evt;
    logic [3:0]       key_code;
    logic             cancel_evt, digit_evt;
    logic             sel_s1, sel_s2, both_high;
    logic             in_run, turn_done, timed_out;

    vend_key_deb #(.KEY_DEB(KEY_DEB)) u_key (
        .clock_in  (clock_in),
        .reset_in  (reset_in),
        .coluna_in (coluna_in),
        .linha_in  (linha_in),
        .key_evt   (key_evt),
        .key_code  (key_code)
    );

    assign cancel_evt = key_evt && (key_code == CANCEL);
    assign digit_evt  = key_evt && is_digit(key_code);

    // Only the selected channel's sensor pair feeds the turn logic
    always_comb begin
        sel_s1 = 1'b1;
        sel_s2 = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_q == 4'(i + 1)) begin
                sel_s1 = sensor1_in[i];
                sel_s2 = sensor2_in[i];
            end
        end
    end

    assign both_high = sel_s1 & sel_s2;
    assign in_run    = (state_q == ST_RUN);
    assign turn_done = in_run && armed_q && both_high && (scnt_q == SW'(SNS_DEB - 1));
    assign timed_out = (tcnt_q == TW'(TURN_TO - 1));

    always_comb begin
        state_nx = state_q;
        ch_nx    = ch_q;
        rem_nx   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (digit_evt && key_code <= 4'(N_CH)) begin
                    ch_nx    = key_code;
                    state_nx = ST_GET_CNT;
                end
            end
            ST_GET_CNT: begin
                if (cancel_evt) begin
                    ch_nx    = 4'd0;
                    state_nx = ST_IDLE;
                end else if (digit_evt) begin
                    if (int'(key_code) > int'(CNT_MAX))
                        rem_nx = CNT_MAX;
                    else
                        rem_nx = CNT_W'(key_code);
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                // Cancel outranks a turn completing in the same cycle
                if (cancel_evt) begin
                    rem_nx   = '0;
                    ch_nx    = 4'd0;
                    state_nx = ST_IDLE;
                end else if (turn_done && rem_q != '0) begin
                    rem_nx = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        ch_nx    = 4'd0;
                        state_nx = ST_IDLE;
                    end
                end else if (timed_out) begin
                    state_nx = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (cancel_evt) begin
                    rem_nx   = '0;
                    ch_nx    = 4'd0;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Arming and both-high debounce; counters are held clear outside RUN
    always_comb begin
        armed_nx = armed_q;
        scnt_nx  = scnt_q;
        tcnt_nx  = '0;
        if (!in_run) begin
            armed_nx = 1'b0;
            scnt_nx  = '0;
        end else begin
            if (!both_high) begin
                armed_nx = 1'b1;
                scnt_nx  = '0;
            end else if (armed_q) begin
                if (turn_done) begin
                    armed_nx = 1'b0;
                    scnt_nx  = '0;
                end else if (scnt_q != SW'(SNS_DEB)) begin
                    scnt_nx = scnt_q + SW'(1);
                end
            end else begin
                scnt_nx = '0;
            end
            if (turn_done)
                tcnt_nx = '0;
            else if (!timed_out)
                tcnt_nx = tcnt_q + TW'(1);
            else
                tcnt_nx = tcnt_q;
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= ST_IDLE;
            ch_q    <= 4'd0;
            rem_q   <= '0;
            armed_q <= 1'b0;
            scnt_q  <= '0;
            tcnt_q  <= '0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            ch_q    <= ch_nx;
            rem_q   <= rem_nx;
            armed_q <= armed_nx;
            scnt_q  <= scnt_nx;
            tcnt_q  <= tcnt_nx;
            busy_q  <= (state_nx == ST_RUN);
            fault_q <= (state_nx == ST_FAULT);
        end
    end

    assign busy_out      = busy_q;
    assign fault_out     = fault_q;
    assign ch_out        = ch_q;
    assign remaining_out = rem_q;

    // Second term drives any parked-between-positions spiral home, except in FAULT
    for (genvar i = 0; i < N_CH; i++) begin : g_rele
        assign rele_out[i] = (in_run && ch_q == 4'(i + 1))
                           | (~sensor1_in[i] & ~sensor2_in[i] & (state_q != ST_FAULT));
    end

endmodule

// File: doc/vend_ctrl_multi.md
VEND_CTRL_MULTI -- requirements
Module: vend_ctrl_multi

Interface
REQ-001 Parameter N_CH, default 4: number of spiral channels (1..9).
REQ-002 Parameter CNT_W, default 4: width of the turn counter.
REQ-003 Parameter KEY_DEB, default 16: number of stable cycles required to accept a key.
REQ-004 Parameter SNS_DEB, default 16: number of stable cycles required to confirm a sensor-pair high.
REQ-005 Parameter TURN_TO, default 4096: cycles allowed per turn before a fault is raised.
REQ-006 clock_in  input  1  system clock; all state changes on its rising edge.
REQ-007 reset_in  input  1  reset, asynchronous and active-low.
REQ-008 coluna_in  input  3  keypad column; one-hot, where 100 is col1 and 001 is col3.
REQ-009 linha_in  input  4  keypad row; one-hot, where 1000 is row1 and 0001 is row4.
REQ-010 sensor1_in  input  N_CH  sensor A, one bit per channel.
REQ-011 sensor2_in  input  N_CH  sensor B, one bit per channel.
REQ-012 rele_out  output  N_CH  motor relay drive, one bit per channel.
REQ-013 busy_out  output  1  high when the block is in RUN.
REQ-014 fault_out  output  1  high when the block is in FAULT.
REQ-015 ch_out  output  4  selected channel; 0 means none selected.
REQ-016 remaining_out  output  CNT_W  number of turns still to dispense.

Function
REQ-017 Key decode: only codes with exactly one column bit and exactly one row bit set are valid.
  - Rows 1-3 map to digit = 3*(row-1)+col, giving 1..9.
  - Row4 col1 is CANCEL; row4 col2 and col3 are ignored.
  - Any other code is treated as "no key".
REQ-018 Key debounce:
  - One press event pulses for 1 cycle once the same valid code has been sampled KEY_DEB consecutive cycles.
  - No further event is issued until "no key" has been sampled at least KEY_DEB consecutive cycles.
  - A code change restarts the count.
REQ-019 FSM states are IDLE, GET_CNT, RUN and FAULT; each transition occurs on the cycle after the press event or the sensor/timeout condition that causes it.
REQ-020 IDLE:
  - Digit d with 1 <= d <= N_CH: ch_out <= d, then go to GET_CNT.
  - Digit d > N_CH: ignored.
  - CANCEL: ignored.
REQ-021 GET_CNT:
  - Digit d: remaining_out <= min(d, 2^CNT_W-1), then go to RUN.
  - CANCEL: ch_out <= 0, then go to IDLE.
REQ-022 Turn detection, per selected channel:
  - The channel becomes armed when either sensor is low.
  - A turn completes when both sensors have been high SNS_DEB consecutive cycles while armed.
  - Turn completion decrements remaining_out by 1 and disarms the channel.
  - At most one decrement occurs per arming.
REQ-023 RUN:
  - remaining_out reaching 0 -> IDLE, with ch_out <= 0.
  - CANCEL -> IDLE immediately, with remaining_out <= 0 and ch_out <= 0.
REQ-024 Turn timeout: a per-turn cycle counter resets on entry to RUN and on every decrement. If it reaches TURN_TO-1 -> FAULT; remaining_out and ch_out are held.
REQ-025 FAULT: only CANCEL exits it, going to IDLE with remaining_out <= 0 and ch_out <= 0; digits are ignored.
REQ-026 Relay drive: rele_out[i] = (state==RUN && ch_out==i+1) | (!sensor1_in[i] & !sensor2_in[i] & state!=FAULT).
  - The second term is a homing assist.
  - rele_out is the only combinational output; all other outputs are registered.
REQ-027 Sensors of unselected channels do not affect the counter, the timeout or the FSM.
REQ-028 A turn completion in the same cycle as a CANCEL event: CANCEL wins and no decrement occurs.
REQ-029 Counter widths: every internal counter saturates or clears explicitly; none wraps.

Reset
REQ-030 While reset_in=0 the following hold:
  - state = IDLE, busy_out = 0, fault_out = 0, ch_out = 0, remaining_out = 0.
  - All debounce, arm and timeout counters = 0.
  - The homing term of rele_out remains active.
REQ-031 Reset asserted mid-RUN: relays of the selected channel drop within the same cycle (asynchronous), except for the homing term.
REQ-032 Reset deassertion does not generate a key event, even if a key is being held at that moment.

Structure
REQ-033 Package vend_pkg holds:
  - the FSM state encoding;
  - the key-code constants (CANCEL, NO_KEY);
  - the digit-decode function.
REQ-034 Key decode and debounce are implemented in sub-module vend_key_deb, instantiated once. Its outputs are key_evt and a 4-bit key code.
REQ-035 Sensor debounce and arming are implemented for the selected channel only, using a single counter set.

Verification
REQ-036 With defaults: hold key 2 for 20 cycles, release 20, hold key 3 for 20 -> ch_out=2, remaining_out=3, busy_out=1, rele_out=0010.
REQ-037 Continuing REQ-036: drive 3 sensor cycles on ch2, each being low 10 then both high 20 -> remaining_out steps 3,2,1,0, then IDLE and rele_out[1]=0.
REQ-038 Key 7 held for 15 cycles only -> no event; key 7 held for 16 cycles -> ignored in IDLE, since 7 > N_CH.
REQ-039 Enter ch1, count 1, with the sensors kept low -> FAULT after 4096 cycles, fault_out=1, rele_out=0; then CANCEL -> IDLE.
REQ-040 Both high for 15 cycles, glitch low for 1 cycle, then high for 16 -> exactly one decrement.
REQ-041 reset_in=0 pulsed mid-RUN with remaining_out=5 -> all outputs return to reset values and the key held across the reset produces no event.
